wash_cycle_sequencer: RTL
=========================

Name: wash_cycle_sequencer

Overview:
Single-FSM sequencer for one full washing-machine program: fill, wash, drain, rinse (optionally twice), spin, end-of-cycle alert. Owns one shared down-counter that times every timed stage; drives the actuator lines (agitator, spin, pump, alert, cold/hot valves) and the timer/stage displays. Sits between the front-panel/sensor inputs and the machine actuators; replaces the separate per-stage timers plus mux with one time-shared counter.

Parameters:
WASH_TIME, 4'd8, wash stage length in ticks (1..15; 0 behaves as 1)
RINSE_TIME, 4'd5, rinse stage length in ticks (same range rule)
SPIN_TIME, 4'd6, spin stage length in ticks (same range rule)
ALERT_TIME, 4'd3, alert duration in DONE, in ticks (same range rule)
FILL_LIMIT, 6'd40, fill timeout in ticks (used only with FILL_TIMEOUT_EN)

Ports:
clock  input  1  system clock, all state on rising edge
restart_n  input  1  synchronous active-low reset
tick  input  1  one-clock timebase strobe; all stage timing counts ticks
start  input  1  level; begins a program from IDLE
extra_rinse  input  1  request a second rinse; sampled with start
hot  input  1  wash temperature select
warm  input  1  wash temperature select
cold  input  1  wash temperature select
full  input  1  tub-full sensor
empty  input  1  tub-empty sensor
agitator  output  1  agitator motor
spin  output  1  spin motor
pump  output  1  drain pump
alert  output  1  buzzer/lamp
cold_valve  output  1  cold water valve
hot_valve  output  1  hot water valve
timer_bus  output  4  remaining ticks of current timed stage, else 0
stage_bus  output  4  current stage code

Behaviour:
- One clock; reset synchronous, active-low: restart_n low at a rising edge -> state IDLE, counter 0, latched temp = cold, extra flag 0, rinse pass 0. All outputs 0 while and after reset. Reset mid-program aborts immediately (valves/pump/motors off next cycle).
- Outputs are Moore, decoded from registered state/counter only; change one clock after the transition edge.
- States / stage_bus codes: IDLE 0, FILL_W 1, WASH 2, DRAIN_W 3, FILL_R 4, RINSE 5, DRAIN_R 6, SPIN 7, DONE 8, FAULT 15.
- IDLE: start=1 -> FILL_W; same edge latches temp select and extra_rinse. Temp priority hot > warm > cold; none set -> cold. start ignored in all other states.
- FILL_W: hot -> hot_valve; warm -> both valves; cold -> cold_valve. full=1 -> WASH.
- WASH: agitator=1; counter loads WASH_TIME on entry; decrements on each tick while >0; tick with counter==1 (or 0) -> DRAIN_W.
- DRAIN_W: pump=1; empty=1 -> FILL_R.
- FILL_R: cold_valve only, regardless of latched temp; full=1 -> RINSE.
- RINSE: agitator=1; timed by RINSE_TIME as WASH -> DRAIN_R.
- DRAIN_R: pump=1; empty=1 -> if extra flag set and rinse pass==0 then set pass=1, go FILL_R; else SPIN.
- SPIN: spin=1, pump=1; timed by SPIN_TIME -> DONE.
- DONE: alert=1; timed by ALERT_TIME -> IDLE; clears extra flag and pass.
- FAULT: alert=1, all other actuators 0; exit only by reset (reachable only with FILL_TIMEOUT_EN).
- timer_bus = counter in WASH/RINSE/SPIN/DONE, 0 in all other states. Exact cycle count: a timed stage of length N ends on the Nth tick after entry.
- Simultaneous full and empty: fill states honour full, drain states honour empty; sensors ignored elsewhere.
- tick on the entry cycle of a timed stage is not counted (counter is loading).
- Never hot_valve and pump together; never agitator and spin together.

Optional Feature:
FILL_TIMEOUT_EN: defined -> a 6-bit fill counter clears on entry to FILL_W/FILL_R, increments per tick; reaching FILL_LIMIT without full -> FAULT (stage 15, alert=1). Not defined -> no fill counter, fill waits for full indefinitely, FAULT unreachable.

Test Plan:
- Reset: restart_n=0 two clocks with start=1, full=1 -> stage_bus=0, all outputs 0, timer_bus=0.
- Normal hot cycle, WASH_TIME=3 RINSE_TIME=2 SPIN_TIME=2 ALERT_TIME=2: start+hot -> stage 1 hot_valve=1; full -> stage 2 timer 3,2,1 per tick, exits on 3rd tick; empty -> 4 cold_valve only; ... stage 7 spin+pump for 2 ticks; stage 8 alert 2 ticks; back to 0.
- Warm select with extra_rinse=1: FILL_W both valves; stages 4,5,6 visited twice, then 7; extra_rinse toggled mid-program has no effect.
- Mid-WASH reset: restart_n=0 while timer_bus=2 -> next cycle stage 0, agitator=0; start again re-runs from stage 1.
- Start while running and tick-on-entry: start pulsed in stage 5 ignored; tick coincident with WASH entry leaves timer_bus=WASH_TIME.
- FILL_TIMEOUT_EN, FILL_LIMIT=4: start, full held 0 -> after 4th tick stage_bus=15, alert=1, valves 0; full=1 then has no effect until reset.

Source files
------------

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine program sequencer: one FSM with a single shared stage timer.
// Optional fill timeout (FAULT state) enabled by defining FILL_TIMEOUT_EN.
module wash_cycle_sequencer #(
  parameter logic [3:0] WASH_TIME  = 4'd8,
  parameter logic [3:0] RINSE_TIME = 4'd5,
  parameter logic [3:0] SPIN_TIME  = 4'd6,
  parameter logic [3:0] ALERT_TIME = 4'd3,
  parameter logic [5:0] FILL_LIMIT = 6'd40
) (
  input  logic       clock,
  input  logic       restart_n,
  input  logic       tick,
  input  logic       start,
  input  logic       extra_rinse,
  input  logic       hot,
  input  logic       warm,
  input  logic       cold,
  input  logic       full,
  input  logic       empty,
  output logic       agitator,
  output logic       spin,
  output logic       pump,
  output logic       alert,
  output logic       cold_valve,
  output logic       hot_valve,
  output logic [3:0] timer_bus,
  output logic [3:0] stage_bus
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, FILL_W = 4'd1, WASH = 4'd2, DRAIN_W = 4'd3, FILL_R = 4'd4,
    RINSE = 4'd5, DRAIN_R = 4'd6, SPIN = 4'd7, DONE = 4'd8, FAULT = 4'd15
  } state_t;

  typedef enum logic [1:0] {TEMP_COLD = 2'd0, TEMP_WARM = 2'd1, TEMP_HOT = 2'd2} temp_t;

  // A zero-length stage still lasts one tick.
  function automatic logic [3:0] stage_len(input logic [3:0] len);
    return (len == 4'd0) ? 4'd1 : len;
  endfunction

  state_t     state, state_nx;
  temp_t      temp, temp_nx;
  logic [3:0] count, count_nx;
  logic       extra, extra_nx;
  logic       pass, pass_nx;
  logic       timer_done;
  logic       agitator_nx, spin_nx, pump_nx, alert_nx, cold_valve_nx, hot_valve_nx;
  logic [3:0] timer_nx;

`ifdef FILL_TIMEOUT_EN
  logic [5:0] fill_cnt, fill_cnt_nx;
  logic       fill_expired;
`endif

  // Next-state, shared-counter update, and decode of the outputs for the next state.
  always_comb begin
    state_nx   = state;
    temp_nx    = temp;
    count_nx   = count;
    extra_nx   = extra;
    pass_nx    = pass;
    timer_done = tick && (count <= 4'd1);
`ifdef FILL_TIMEOUT_EN
    fill_cnt_nx  = fill_cnt;
    fill_expired = tick && (({1'b0, fill_cnt} + 7'd1) >= {1'b0, FILL_LIMIT});
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = FILL_W;
          extra_nx = extra_rinse;
          pass_nx  = 1'b0;
`ifdef FILL_TIMEOUT_EN
          fill_cnt_nx = 6'd0;
`endif
          if (hot)       temp_nx = TEMP_HOT;
          else if (warm) temp_nx = TEMP_WARM;
          else           temp_nx = TEMP_COLD;
        end else begin
          state_nx = IDLE;
        end
      end
      FILL_W: begin
        if (full) begin
          state_nx = WASH;
          count_nx = stage_len(WASH_TIME);
        end
`ifdef FILL_TIMEOUT_EN
        else if (fill_expired) state_nx = FAULT;
        else if (tick) fill_cnt_nx = fill_cnt + 6'd1;
`endif
        else state_nx = FILL_W;
      end
      WASH: begin
        if (timer_done) begin
          state_nx = DRAIN_W;
          count_nx = 4'd0;
        end else if (tick) count_nx = count - 4'd1;
        else count_nx = count;
      end
      DRAIN_W: begin
        if (empty) begin
          state_nx = FILL_R;
`ifdef FILL_TIMEOUT_EN
          fill_cnt_nx = 6'd0;
`endif
        end else begin
          state_nx = DRAIN_W;
        end
      end
      FILL_R: begin
        if (full) begin
          state_nx = RINSE;
          count_nx = stage_len(RINSE_TIME);
        end
`ifdef FILL_TIMEOUT_EN
        else if (fill_expired) state_nx = FAULT;
        else if (tick) fill_cnt_nx = fill_cnt + 6'd1;
`endif
        else state_nx = FILL_R;
      end
      RINSE: begin
        if (timer_done) begin
          state_nx = DRAIN_R;
          count_nx = 4'd0;
        end else if (tick) count_nx = count - 4'd1;
        else count_nx = count;
      end
      DRAIN_R: begin
        if (empty && extra && !pass) begin
          state_nx = FILL_R;
          pass_nx  = 1'b1;
`ifdef FILL_TIMEOUT_EN
          fill_cnt_nx = 6'd0;
`endif
        end else if (empty) begin
          state_nx = SPIN;
          count_nx = stage_len(SPIN_TIME);
        end else begin
          state_nx = DRAIN_R;
        end
      end
      SPIN: begin
        if (timer_done) begin
          state_nx = DONE;
          count_nx = stage_len(ALERT_TIME);
        end else if (tick) count_nx = count - 4'd1;
        else count_nx = count;
      end
      DONE: begin
        if (timer_done) begin
          state_nx = IDLE;
          count_nx = 4'd0;
          extra_nx = 1'b0;
          pass_nx  = 1'b0;
        end else if (tick) count_nx = count - 4'd1;
        else count_nx = count;
      end
      FAULT: state_nx = FAULT;
      default: begin
        state_nx = IDLE;
        count_nx = 4'd0;
      end
    endcase

    agitator_nx   = 1'b0;
    spin_nx       = 1'b0;
    pump_nx       = 1'b0;
    alert_nx      = 1'b0;
    cold_valve_nx = 1'b0;
    hot_valve_nx  = 1'b0;
    timer_nx      = 4'd0;
    case (state_nx)
      FILL_W: begin
        hot_valve_nx  = (temp_nx != TEMP_COLD);
        cold_valve_nx = (temp_nx != TEMP_HOT);
      end
      WASH, RINSE: begin
        agitator_nx = 1'b1;
        timer_nx    = count_nx;
      end
      DRAIN_W, DRAIN_R: pump_nx = 1'b1;
      FILL_R: cold_valve_nx = 1'b1;
      SPIN: begin
        spin_nx  = 1'b1;
        pump_nx  = 1'b1;
        timer_nx = count_nx;
      end
      DONE: begin
        alert_nx = 1'b1;
        timer_nx = count_nx;
      end
      FAULT: alert_nx = 1'b1;
      default: agitator_nx = 1'b0;
    endcase
  end

  // State, counter, latched program options and registered actuator outputs.
  always_ff @(posedge clock) begin
    if (!restart_n) begin
      state      <= IDLE;
      temp       <= TEMP_COLD;
      count      <= 4'd0;
      extra      <= 1'b0;
      pass       <= 1'b0;
      agitator   <= 1'b0;
      spin       <= 1'b0;
      pump       <= 1'b0;
      alert      <= 1'b0;
      cold_valve <= 1'b0;
      hot_valve  <= 1'b0;
      timer_bus  <= 4'd0;
      stage_bus  <= 4'd0;
`ifdef FILL_TIMEOUT_EN
      fill_cnt   <= 6'd0;
`endif
    end else begin
      state      <= state_nx;
      temp       <= temp_nx;
      count      <= count_nx;
      extra      <= extra_nx;
      pass       <= pass_nx;
      agitator   <= agitator_nx;
      spin       <= spin_nx;
      pump       <= pump_nx;
      alert      <= alert_nx;
      cold_valve <= cold_valve_nx;
      hot_valve  <= hot_valve_nx;
      timer_bus  <= timer_nx;
      stage_bus  <= state_nx;
`ifdef FILL_TIMEOUT_EN
      fill_cnt   <= fill_cnt_nx;
`endif
    end
  end

endmodule
